// File: rtl/wb_write_queue_if.sv
// Bundles the write-back queue's producer, register-file and lookup signals.
// The queue itself connects through the slave modport. The bench, or whatever
// drives the channels, connects through master.
interface wb_write_queue_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 64
);
  // load result channel
  logic                     ld_valid;
  logic [AW-1:0]            ld_addr;
  logic [DW-1:0]            ld_data;
  logic                     ld_ready;
  // ALU result channel
  logic                     alu_valid;
  logic [AW-1:0]            alu_addr;
  logic [DW-1:0]            alu_data;
  logic                     alu_ready;
  // register file write port
  logic                     wb_stall;
  logic [AW-1:0]            Ad_c;
  logic [DW-1:0]            data_wr;
  logic                     wr_acc;
  // operand forwarding lookup
  logic [AW-1:0]            look_a;
  logic [AW-1:0]            look_b;
  logic                     hit_a;
  logic [DW-1:0]            fwd_a;
  logic                     hit_b;
  logic [DW-1:0]            fwd_b;
  // occupancy
  logic [$clog2(DEPTH):0]   count;
  logic                     empty;

  modport slave (
    input  ld_valid, ld_addr, ld_data,
    input  alu_valid, alu_addr, alu_data,
    input  wb_stall, look_a, look_b,
    output ld_ready, alu_ready,
    output Ad_c, data_wr, wr_acc,
    output hit_a, fwd_a, hit_b, fwd_b,
    output count, empty
  );

  modport master (
    output ld_valid, ld_addr, ld_data,
    output alu_valid, alu_addr, alu_data,
    output wb_stall, look_a, look_b,
    input  ld_ready, alu_ready,
    input  Ad_c, data_wr, wr_acc,
    input  hit_a, fwd_a, hit_b, fwd_b,
    input  count, empty
  );
endinterface

// File: rtl/wb_write_queue.sv
// In-order write-back queue in front of the register file's single write port.
// Load and ALU results are enqueued, with the load ahead of the ALU result when
// both arrive together. The head entry drains one per cycle unless stalled.
// The stored entries can be searched so operand fetch can forward values that
// have not yet reached the register file.
module wb_write_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  wb_write_queue_if.slave  bus
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_q [DEPTH];
  logic [AW-1:0] addr_d [DEPTH];
  logic [DW-1:0] data_q [DEPTH];
  logic [DW-1:0] data_d [DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic          empty_w;
  logic          pop_w;
  logic [CW:0]   free_w;
  logic          ld_ready_w;
  logic          alu_ready_w;
  logic          push_ld_w;
  logic          push_alu_w;
  logic [PW-1:0] alu_slot_w;
  logic          hit_a_w, hit_b_w;
  logic [DW-1:0] fwd_a_w, fwd_b_w;

  // Handshake: a slot freed by this cycle's drain can be reused at the same
  // edge. Ready is derived from occupancy and the other channel's valid only,
  // never from the channel's own valid.
  always_comb begin
    empty_w     = (count_q == '0);
    pop_w       = !empty_w && !bus.wb_stall;
    free_w      = (CW+1)'(DEPTH) - {1'b0, count_q} + {{CW{1'b0}}, pop_w};
    ld_ready_w  = (free_w >= (CW+1)'(1));
    alu_ready_w = (free_w >= (CW+1)'(2)) ||
                  ((free_w >= (CW+1)'(1)) && !bus.ld_valid);
    push_ld_w   = bus.ld_valid && ld_ready_w;
    push_alu_w  = bus.alu_valid && alu_ready_w;
  end

  // Next state: the load takes the first free slot, and the ALU result takes
  // the slot after it when both are accepted at the same edge.
  always_comb begin
    addr_d     = addr_q;
    data_d     = data_q;
    alu_slot_w = wr_ptr_q + PW'(push_ld_w);
    if (push_ld_w) begin
      addr_d[wr_ptr_q] = bus.ld_addr;
      data_d[wr_ptr_q] = bus.ld_data;
    end
    if (push_alu_w) begin
      addr_d[alu_slot_w] = bus.alu_addr;
      data_d[alu_slot_w] = bus.alu_data;
    end
    rd_ptr_d = rd_ptr_q + PW'(pop_w);
    wr_ptr_d = wr_ptr_q + PW'(push_ld_w) + PW'(push_alu_w);
    count_d  = count_q + CW'(push_ld_w) + CW'(push_alu_w) - CW'(pop_w);
  end

  // State registers; reset discards every queued write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_q[i] <= '0;
        data_q[i] <= '0;
      end
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      addr_q   <= addr_d;
      data_q   <= data_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Forwarding lookup over stored entries only. The search walks from oldest
  // to youngest so that a later match overrides an earlier one. The head entry
  // takes part even while it is being written.
  always_comb begin
    hit_a_w = 1'b0;
    fwd_a_w = '0;
    hit_b_w = 1'b0;
    fwd_b_w = '0;
    for (int i = 0; i < DEPTH; i++) begin
      if (CW'(i) < count_q) begin
        if (addr_q[rd_ptr_q + PW'(i)] == bus.look_a) begin
          hit_a_w = 1'b1;
          fwd_a_w = data_q[rd_ptr_q + PW'(i)];
        end
        if (addr_q[rd_ptr_q + PW'(i)] == bus.look_b) begin
          hit_b_w = 1'b1;
          fwd_b_w = data_q[rd_ptr_q + PW'(i)];
        end
      end
    end
  end

  assign bus.ld_ready  = ld_ready_w;
  assign bus.alu_ready = alu_ready_w;
  assign bus.wr_acc    = pop_w;
  assign bus.Ad_c      = empty_w ? '0 : addr_q[rd_ptr_q];
  assign bus.data_wr   = empty_w ? '0 : data_q[rd_ptr_q];
  assign bus.hit_a     = hit_a_w;
  assign bus.fwd_a     = fwd_a_w;
  assign bus.hit_b     = hit_b_w;
  assign bus.fwd_b     = fwd_b_w;
  assign bus.count     = count_q;
  assign bus.empty     = empty_w;

endmodule

// File: tb/tb_wb_write_queue.sv
// Directed and random stimulus for wb_write_queue. A queue of expected
// register-file writes predicts every drained entry, the occupancy, the ready
// signals and the forwarding lookups.
module tb_wb_write_queue;

  logic clk;
  logic rst_n;

  wb_write_queue_if #(.DEPTH(4), .AW(5), .DW(64)) bus ();

  wb_write_queue #(.DEPTH(4), .AW(5), .DW(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  typedef struct {
    logic [4:0]  a;
    logic [63:0] d;
  } ent_t;

  ent_t sbq[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_lookup(input logic [4:0] a, output logic hit, output logic [63:0] fwd);
    hit = 1'b0;
    fwd = '0;
    for (int i = sbq.size() - 1; i >= 0; i--) begin
      if (sbq[i].a == a) begin
        hit = 1'b1;
        fwd = sbq[i].d;
        break;
      end
    end
  endtask

  // Check all outputs for the inputs that are currently applied, advance one
  // clock edge, then update the expected-write queue the same way.
  task automatic tick();
    int          n;
    int          free;
    logic        m_pop;
    logic        e_ldr;
    logic        e_alur;
    logic        hit;
    logic [63:0] fwd;
    ent_t        e;
    #1;
    n      = sbq.size();
    m_pop  = (n != 0) && !bus.wb_stall;
    free   = 4 - n + (m_pop ? 1 : 0);
    e_ldr  = (free >= 1);
    e_alur = (free >= 2) || ((free >= 1) && !bus.ld_valid);
    chk("count", 64'(bus.count), 64'(n));
    chk("empty", 64'(bus.empty), 64'(n == 0));
    chk("wr_acc", 64'(bus.wr_acc), 64'(m_pop));
    if (n != 0) begin
      chk("Ad_c", 64'(bus.Ad_c), 64'(sbq[0].a));
      chk("data_wr", bus.data_wr, sbq[0].d);
    end else begin
      chk("Ad_c_idle", 64'(bus.Ad_c), 64'd0);
      chk("data_wr_idle", bus.data_wr, 64'd0);
    end
    chk("ld_ready", 64'(bus.ld_ready), 64'(e_ldr));
    chk("alu_ready", 64'(bus.alu_ready), 64'(e_alur));
    model_lookup(bus.look_a, hit, fwd);
    chk("hit_a", 64'(bus.hit_a), 64'(hit));
    chk("fwd_a", bus.fwd_a, fwd);
    model_lookup(bus.look_b, hit, fwd);
    chk("hit_b", 64'(bus.hit_b), 64'(hit));
    chk("fwd_b", bus.fwd_b, fwd);
    @(posedge clk);
    if (!rst_n) begin
      sbq.delete();
    end else begin
      if (m_pop) void'(sbq.pop_front());
      if (bus.ld_valid && e_ldr) begin
        e.a = bus.ld_addr;
        e.d = bus.ld_data;
        sbq.push_back(e);
      end
      if (bus.alu_valid && e_alur) begin
        e.a = bus.alu_addr;
        e.d = bus.alu_data;
        sbq.push_back(e);
      end
    end
    @(negedge clk);
  endtask

  task automatic set_ld(input logic v, input logic [4:0] a, input logic [63:0] d);
    bus.ld_valid = v;
    bus.ld_addr  = a;
    bus.ld_data  = d;
  endtask

  task automatic set_alu(input logic v, input logic [4:0] a, input logic [63:0] d);
    bus.alu_valid = v;
    bus.alu_addr  = a;
    bus.alu_data  = d;
  endtask

  task automatic idle(input int cycles);
    set_ld(1'b0, 5'd0, 64'd0);
    set_alu(1'b0, 5'd0, 64'd0);
    for (int i = 0; i < cycles; i++) tick();
  endtask

  initial begin
    rst_n        = 1'b0;
    bus.wb_stall = 1'b0;
    bus.look_a   = 5'd0;
    bus.look_b   = 5'd0;
    set_ld(1'b0, 5'd0, 64'd0);
    set_alu(1'b0, 5'd0, 64'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // reset state, then a single load drains on the next cycle
    idle(1);
    set_ld(1'b1, 5'd1, 64'd1);
    tick();
    idle(2);

    // load and ALU at the same edge: the load is written first
    bus.look_a = 5'd3;
    bus.look_b = 5'd4;
    set_ld(1'b1, 5'd3, 64'hA);
    set_alu(1'b1, 5'd4, 64'hB);
    tick();
    idle(3);

    // stalled fill to full, ALU refused while full, then drain in order
    bus.wb_stall = 1'b1;
    bus.look_a   = 5'd2;
    for (int i = 1; i <= 4; i++) begin
      set_alu(1'b1, 5'(i), 64'h100 + 64'(i));
      tick();
    end
    set_alu(1'b1, 5'd9, 64'h999);
    tick();
    bus.wb_stall = 1'b0;
    idle(5);

    // full queue: simultaneous push and pop, then only the load fits
    bus.wb_stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_ld(1'b1, 5'(10 + i), 64'h200 + 64'(i));
      tick();
    end
    bus.wb_stall = 1'b0;
    set_ld(1'b1, 5'd14, 64'h214);
    tick();
    set_ld(1'b1, 5'd15, 64'h215);
    set_alu(1'b1, 5'd16, 64'h216);
    tick();
    idle(6);

    // youngest duplicate forwarded, miss returns zero, register 0 forwarded
    bus.wb_stall = 1'b1;
    set_ld(1'b1, 5'd5, 64'h11);
    tick();
    set_ld(1'b1, 5'd5, 64'h22);
    tick();
    set_ld(1'b1, 5'd0, 64'h33);
    bus.look_a = 5'd5;
    bus.look_b = 5'd6;
    tick();
    set_ld(1'b0, 5'd0, 64'd0);
    bus.look_b = 5'd0;
    tick();
    bus.wb_stall = 1'b0;
    idle(4);

    // reset with three entries pending drops them all
    bus.wb_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      set_alu(1'b1, 5'(20 + i), 64'h300 + 64'(i));
      tick();
    end
    set_alu(1'b0, 5'd0, 64'd0);
    rst_n = 1'b0;
    tick();
    rst_n        = 1'b1;
    bus.wb_stall = 1'b0;
    idle(3);

    // random traffic with stalls and lookups over a small address range
    for (int i = 0; i < 300; i++) begin
      bus.wb_stall = ($urandom_range(0, 3) == 0);
      set_ld($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
             {32'($urandom), 32'($urandom)});
      set_alu($urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
              {32'($urandom), 32'($urandom)});
      bus.look_a = 5'($urandom_range(0, 7));
      bus.look_b = 5'($urandom_range(0, 7));
      tick();
    end
    bus.wb_stall = 1'b0;
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
